rcn_fifo_param: RTL and testbench
=================================

# rcn_fifo_param

Parametrised ring-network (rcn) packet FIFO for buffering rcn packets between ring nodes and local agents. Width, depth and almost-full threshold are configurable, with a fill-level output and a resettable peak-level watermark. Reads are first-word-fall-through. The MSB of a packet is its valid bit: it is regenerated on the output from the FIFO state and is not stored. Optional sticky overflow/underflow flags can be compiled in.

## Interface
- WIDTH, 69, packet width including valid bit (MSB); ≥ 2
- DEPTH, 4, entries; ≥ 2, any integer (power of two not required)
- AF_LEVEL, DEPTH-1, almost_full asserts when level ≥ AF_LEVEL; 1..DEPTH
- LW (localparam), $clog2(DEPTH+1), level/watermark width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rcn_in  in  WIDTH  packet in; bits [WIDTH-2:0] are stored, MSB is ignored
- push  in  1  write strobe
- full  out  1  level == DEPTH
- almost_full  out  1  level ≥ AF_LEVEL
- rcn_out  out  WIDTH  {!empty, head entry [WIDTH-2:0]}
- pop  in  1  read strobe; consumes the current rcn_out
- empty  out  1  level == 0
- level  out  LW  current occupancy, 0..DEPTH
- wm_clr  in  1  watermark clear strobe
- watermark  out  LW  peak level since reset or last wm_clr
- ovf  out  1  sticky overflow (RCN_FIFO_ERR_EN only, else tied 0)
- udf  out  1  sticky underflow (RCN_FIFO_ERR_EN only, else tied 0)

## Operation
- State: wr_ptr, rd_ptr (range 0..DEPTH-1), cnt (LW bits), watermark; storage is DEPTH × (WIDTH-1) with no reset.
- Accepted push (acc_w) = push & (!full | pop). Accepted pop (acc_r) = pop & !empty.
- acc_w: writes mem[wr_ptr]; wr_ptr advances. acc_r: rd_ptr advances. Both pointers wrap from DEPTH-1 to 0 explicitly, never by binary overflow.
- cnt: +1 on acc_w only, -1 on acc_r only, unchanged when both or neither occur.
- push & pop while full: both are accepted and level stays DEPTH.
- push & pop while empty: the push is accepted and the pop is ignored (no bypass); level becomes 1.
- push while full without pop: the data is dropped and the state is unchanged.
- pop while empty: no effect.
- rcn_out: the valid bit is !empty. The payload is mem[rd_ptr] when non-empty and unspecified when empty, so checkers must qualify payload with the valid bit.
- watermark: on each edge, watermark <= wm_clr ? cnt_next : max(watermark, cnt_next).
- ovf is set by push & full & !pop. udf is set by pop & empty. Both are cleared only by rst.

## Timing
- Reset: wr_ptr = rd_ptr = 0, cnt = 0, watermark = 0, ovf = udf = 0. Hence empty=1, full=0, almost_full=0, level=0, rcn_out MSB=0.
- Reset asserted mid-operation discards all contents immediately (asynchronous); memory contents are not cleared.
- full, empty, almost_full, level and watermark are decoded from registers only, with no combinational path from push or pop.
- Write-to-read latency is 1 cycle: a packet pushed at edge N appears on rcn_out after edge N if the FIFO was empty.
- A pop at edge N presents the next entry (or valid=0) after edge N.
- rcn_out depends combinationally only on registers and memory.

## Configuration
- RCN_FIFO_ERR_EN defined: ovf/udf sticky registers and their set logic are present.
- RCN_FIFO_ERR_EN undefined: ovf and udf are constant 0 and no error flops exist. All other behaviour is identical, including dropping pushes when full.

## Structure
- Package rcn_pkg holds:
  - RCN_WIDTH = 69
  - RCN_VALID_BIT = 68
  - rcn_pkt_t typedef (logic [68:0])
- Sub-module rcn_fifo_ptr: parametrised modulo-DEPTH pointer with an increment enable and async reset. It is instantiated twice, for write and read.
- Occupancy, flag and watermark logic stay in the top level.

## Test plan
- Reset then idle, DEPTH=4: empty=1, level=0, rcn_out[68]=0, watermark=0.
- Push A,B,C,D on consecutive cycles, then push E without pop: full=1 after the 4th edge and E is dropped. Pop ×4 returns A,B,C,D, then empty=1. ovf=1 with the macro, 0 without.
- Simultaneous push/pop while full (DEPTH=4), for 10 cycles: level stays 4 and the output order is preserved with no loss.
- push+pop while empty: level=1 and the pushed word is visible next cycle. A pop on an empty FIFO sets udf (macro on) with no pointer change.
- DEPTH=5, AF_LEVEL=3: push 3 gives almost_full=1, and 12 push/pop cycles exercise pointer wrap with data intact. Watermark=5 after filling; wm_clr while level=2 gives watermark=2.
- Assert rst mid-stream at level=3: empty=1 and level=0 immediately. The first push after reset is read back correctly.

Source files
------------

// File: rtl/rcn_pkg.sv
// rcn_pkg: shared definitions for ring-network (rcn) packets.
//   RCN_WIDTH     - full packet width including the valid bit
//   RCN_VALID_BIT - index of the valid bit (packet MSB)
//   rcn_pkt_t     - packet type
//   rcn_pkt_valid - helper returning the valid bit of a packet
package rcn_pkg;

    localparam int RCN_WIDTH     = 69;
    localparam int RCN_VALID_BIT = 68;

    typedef logic [RCN_WIDTH-1:0] rcn_pkt_t;

    // Extract the valid bit of a packet.
    function automatic logic rcn_pkt_valid(input rcn_pkt_t pkt);
        return pkt[RCN_VALID_BIT];
    endfunction

endpackage

// File: rtl/rcn_fifo_ptr.sv
// rcn_fifo_ptr: modulo-DEPTH pointer used for the FIFO write and read sides.
// The pointer wraps from DEPTH-1 to 0 explicitly, so DEPTH need not be a
// power of two.
// Ports:
//   clk - clock
//   rst - asynchronous active-high reset (pointer returns to 0)
//   inc - advance the pointer by one on the next edge
//   ptr - current pointer value, 0..DEPTH-1
module rcn_fifo_ptr
    import rcn_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [PW-1:0] ptr_r;
    logic [PW-1:0] ptr_nxt_s;

    // Next pointer: hold, wrap at the last slot, or step by one.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (!inc) begin
            ptr_nxt_s = ptr_r;
        end else if (ptr_r == LAST_PTR) begin
            ptr_nxt_s = PW'(0);
        end else begin
            ptr_nxt_s = ptr_r + PW'(1);
        end
    end

    // Pointer register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= PW'(0);
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/rcn_fifo_param.sv
// rcn_fifo_param: parametrised first-word-fall-through FIFO for rcn packets.
// The packet MSB (valid bit) is not stored; on the output it is regenerated
// as !empty. Only bits [WIDTH-2:0] are kept in the storage array.
// Optional feature: define RCN_FIFO_ERR_EN to build the sticky ovf/udf
// flags; otherwise both outputs are constant 0 and no error flops exist.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   rcn_in, push - write packet and strobe (dropped when full without pop)
//   rcn_out, pop - head packet {!empty, payload} and read strobe
//   full, almost_full, empty, level - occupancy status (register-decoded)
//   wm_clr, watermark - peak-level tracker and its clear strobe
//   ovf, udf     - sticky overflow / underflow flags
module rcn_fifo_param
    import rcn_pkg::*;
#(
    parameter int WIDTH    = RCN_WIDTH,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    localparam int LW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rcn_in,
    input  logic             push,
    output logic             full,
    output logic             almost_full,
    output logic [WIDTH-1:0] rcn_out,
    input  logic             pop,
    output logic             empty,
    output logic [LW-1:0]    level,
    input  logic             wm_clr,
    output logic [LW-1:0]    watermark,
    output logic             ovf,
    output logic             udf
);

    localparam int DW = WIDTH - 1;
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem_r [0:DEPTH-1];
    logic [PW-1:0] wr_ptr_s;
    logic [PW-1:0] rd_ptr_s;
    logic [LW-1:0] cnt_r;
    logic [LW-1:0] cnt_nxt_s;
    logic [LW-1:0] watermark_r;
    logic [LW-1:0] wm_nxt_s;
    logic          full_s;
    logic          empty_s;
    logic          acc_w_s;
    logic          acc_r_s;
    logic          unused_s;

    // The incoming valid bit carries no information for storage.
    assign unused_s = rcn_in[WIDTH-1];

    assign full_s  = (cnt_r == LW'(DEPTH));
    assign empty_s = (cnt_r == LW'(0));

    // A push is taken when there is room or when a simultaneous pop frees a
    // slot; a pop on an empty FIFO is ignored, so push+pop while empty only
    // writes (no bypass).
    assign acc_w_s = push & (~full_s | pop);
    assign acc_r_s = pop & ~empty_s;

    rcn_fifo_ptr #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (acc_w_s),
        .ptr (wr_ptr_s)
    );

    rcn_fifo_ptr #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (acc_r_s),
        .ptr (rd_ptr_s)
    );

    // Storage array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (acc_w_s) begin
            mem_r[wr_ptr_s] <= rcn_in[DW-1:0];
        end
    end

    // Next occupancy: simultaneous accepted push and pop cancel out.
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({acc_w_s, acc_r_s})
            2'b10:   cnt_nxt_s = cnt_r + LW'(1);
            2'b01:   cnt_nxt_s = cnt_r - LW'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Next watermark tracks the post-edge level, restarting on wm_clr.
    always_comb begin
        wm_nxt_s = watermark_r;
        if (wm_clr) begin
            wm_nxt_s = cnt_nxt_s;
        end else if (cnt_nxt_s > watermark_r) begin
            wm_nxt_s = cnt_nxt_s;
        end else begin
            wm_nxt_s = watermark_r;
        end
    end

    // Occupancy and watermark registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= LW'(0);
            watermark_r <= LW'(0);
        end else begin
            cnt_r       <= cnt_nxt_s;
            watermark_r <= wm_nxt_s;
        end
    end

`ifdef RCN_FIFO_ERR_EN
    logic ovf_r;
    logic udf_r;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | (push & full_s & ~pop);
            udf_r <= udf_r | (pop & empty_s);
        end
    end

    assign ovf = ovf_r;
    assign udf = udf_r;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

    // All status outputs are decoded from registers only.
    assign full        = full_s;
    assign empty       = empty_s;
    assign almost_full = (cnt_r >= LW'(AF_LEVEL));
    assign level       = cnt_r;
    assign watermark   = watermark_r;
    assign rcn_out     = {~empty_s, mem_r[rd_ptr_s]};

endmodule

// File: tb/tb_rcn_fifo_param.sv
// Self-checking bench for rcn_fifo_param: two instances (DEPTH=4 default
// threshold, DEPTH=5 with AF_LEVEL=3) driven by directed and random
// stimulus and compared every cycle against a queue-based model.
module tb_rcn_fifo_param;
    import rcn_pkg::*;

`ifdef RCN_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  push_v;
    logic [1:0]  pop_v;
    logic [1:0]  clr_v;
    logic [1:0]  msb_v;
    logic [67:0] din [2];

    rcn_pkt_t    out_o [2];
    logic [2:0]  lvl_o [2];
    logic [2:0]  wm_o  [2];
    logic [1:0]  full_o, af_o, empty_o, ovf_o, udf_o;

    // Model state
    logic [67:0] mq [2][$];
    int          m_wm  [2];
    bit          m_ovf [2];
    bit          m_udf [2];
    int          m_depth [2] = '{4, 5};
    int          m_af    [2] = '{3, 3};

    int n_vec = 0;
    int n_err = 0;

    rcn_fifo_param #(.DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .rcn_in({msb_v[0], din[0]}), .push(push_v[0]),
        .full(full_o[0]), .almost_full(af_o[0]), .rcn_out(out_o[0]), .pop(pop_v[0]),
        .empty(empty_o[0]), .level(lvl_o[0]), .wm_clr(clr_v[0]), .watermark(wm_o[0]),
        .ovf(ovf_o[0]), .udf(udf_o[0])
    );

    rcn_fifo_param #(.DEPTH(5), .AF_LEVEL(3)) dut5 (
        .clk(clk), .rst(rst), .rcn_in({msb_v[1], din[1]}), .push(push_v[1]),
        .full(full_o[1]), .almost_full(af_o[1]), .rcn_out(out_o[1]), .pop(pop_v[1]),
        .empty(empty_o[1]), .level(lvl_o[1]), .wm_clr(clr_v[1]), .watermark(wm_o[1]),
        .ovf(ovf_o[1]), .udf(udf_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int i, input logic [67:0] act,
                       input logic [67:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, i, act, exp, $time);
        end
    endtask

    function automatic logic [67:0] rand68();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[67:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_wm[i]  = 0;
            m_ovf[i] = 1'b0;
            m_udf[i] = 1'b0;
        end
    endtask

    // Apply one clock edge worth of behaviour to the model.
    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            int n;
            bit dw, dr;
            n  = mq[i].size();
            dw = push_v[i] && (n < m_depth[i] || pop_v[i]);
            dr = pop_v[i] && (n > 0);
            if (push_v[i] && n == m_depth[i] && !pop_v[i]) m_ovf[i] = 1'b1;
            if (pop_v[i] && n == 0) m_udf[i] = 1'b1;
            if (dr) void'(mq[i].pop_front());
            if (dw) mq[i].push_back(din[i]);
            n = mq[i].size();
            if (clr_v[i]) m_wm[i] = n;
            else if (n > m_wm[i]) m_wm[i] = n;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int n;
            n = mq[i].size();
            chk("level", i, 68'(lvl_o[i]), 68'(n));
            chk("empty", i, 68'(empty_o[i]), 68'(n == 0));
            chk("full", i, 68'(full_o[i]), 68'(n == m_depth[i]));
            chk("almost_full", i, 68'(af_o[i]), 68'(n >= m_af[i]));
            chk("watermark", i, 68'(wm_o[i]), 68'(m_wm[i]));
            chk("valid", i, 68'(rcn_pkt_valid(out_o[i])), 68'(n != 0));
            if (n != 0) chk("payload", i, out_o[i][67:0], mq[i][0]);
            chk("ovf", i, 68'(ovf_o[i]), 68'(ERR_EN & m_ovf[i]));
            chk("udf", i, 68'(udf_o[i]), 68'(ERR_EN & m_udf[i]));
        end
    endtask

    // Drive one cycle of inputs, update the model at the edge, check at negedge.
    task automatic step(input logic [1:0] pu, input logic [1:0] po, input logic [1:0] cl,
                        input logic [67:0] d0, input logic [67:0] d1);
        push_v = pu;
        pop_v  = po;
        clr_v  = cl;
        din[0] = d0;
        din[1] = d1;
        msb_v  = 2'($urandom);
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic rstep(input logic [1:0] pu, input logic [1:0] po, input logic [1:0] cl);
        step(pu, po, cl, rand68(), rand68());
    endtask

    initial begin
        rst    = 1'b1;
        push_v = 2'b00;
        pop_v  = 2'b00;
        clr_v  = 2'b00;
        msb_v  = 2'b00;
        din[0] = 68'd0;
        din[1] = 68'd0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        compare_all();
        chk("lit_reset_level", 0, 68'(lvl_o[0]), 68'd0);
        chk("lit_reset_empty", 0, 68'(empty_o[0]), 68'd1);
        chk("lit_reset_valid", 0, 68'(out_o[0][68]), 68'd0);
        chk("lit_reset_wm", 0, 68'(wm_o[0]), 68'd0);

        // Fill DEPTH=4 with A..D, then a dropped push of E.
        step(2'b01, 2'b00, 2'b00, 68'hA, 68'd0);
        step(2'b01, 2'b00, 2'b00, 68'hB, 68'd0);
        step(2'b01, 2'b00, 2'b00, 68'hC, 68'd0);
        step(2'b01, 2'b00, 2'b00, 68'hD, 68'd0);
        chk("lit_full_after_4", 0, 68'(full_o[0]), 68'd1);
        step(2'b01, 2'b00, 2'b00, 68'hE, 68'd0);
        chk("lit_level_after_drop", 0, 68'(lvl_o[0]), 68'd4);
        chk("lit_ovf", 0, 68'(ovf_o[0]), 68'(ERR_EN));
        chk("lit_head_A", 0, out_o[0][67:0], 68'hA);
        step(2'b00, 2'b01, 2'b00, 68'd0, 68'd0);
        chk("lit_head_B", 0, out_o[0][67:0], 68'hB);
        step(2'b00, 2'b01, 2'b00, 68'd0, 68'd0);
        chk("lit_head_C", 0, out_o[0][67:0], 68'hC);
        step(2'b00, 2'b01, 2'b00, 68'd0, 68'd0);
        chk("lit_head_D", 0, out_o[0][67:0], 68'hD);
        step(2'b00, 2'b01, 2'b00, 68'd0, 68'd0);
        chk("lit_empty_after_drain", 0, 68'(empty_o[0]), 68'd1);
        step(2'b00, 2'b01, 2'b00, 68'd0, 68'd0);
        chk("lit_udf", 0, 68'(udf_o[0]), 68'(ERR_EN));

        // Full with simultaneous push/pop for 10 cycles.
        repeat (4) rstep(2'b01, 2'b00, 2'b00);
        repeat (10) rstep(2'b01, 2'b01, 2'b00);
        chk("lit_full_pushpop_level", 0, 68'(lvl_o[0]), 68'd4);
        repeat (4) rstep(2'b00, 2'b01, 2'b00);

        // push+pop while empty: push taken, pop ignored.
        step(2'b01, 2'b01, 2'b00, 68'h55, 68'd0);
        chk("lit_pp_empty_level", 0, 68'(lvl_o[0]), 68'd1);
        chk("lit_pp_empty_data", 0, out_o[0][67:0], 68'h55);
        rstep(2'b00, 2'b01, 2'b00);

        // DEPTH=5, AF_LEVEL=3.
        rstep(2'b10, 2'b00, 2'b00);
        rstep(2'b10, 2'b00, 2'b00);
        chk("lit_af_at_2", 1, 68'(af_o[1]), 68'd0);
        rstep(2'b10, 2'b00, 2'b00);
        chk("lit_af_at_3", 1, 68'(af_o[1]), 68'd1);
        rstep(2'b10, 2'b00, 2'b00);
        rstep(2'b10, 2'b00, 2'b00);
        chk("lit_wm_5", 1, 68'(wm_o[1]), 68'd5);
        repeat (3) rstep(2'b00, 2'b10, 2'b00);
        rstep(2'b00, 2'b00, 2'b10);
        chk("lit_wm_clr_2", 1, 68'(wm_o[1]), 68'd2);
        repeat (12) rstep(2'b10, 2'b10, 2'b00);
        chk("lit_wrap_level", 1, 68'(lvl_o[1]), 68'd2);

        // Random traffic in push-heavy, pop-heavy and balanced phases.
        for (int ph = 0; ph < 3; ph++) begin
            int pp, pq;
            pp = (ph == 0) ? 75 : (ph == 1) ? 30 : 55;
            pq = (ph == 0) ? 30 : (ph == 1) ? 75 : 50;
            repeat (600) begin
                logic [1:0] pu, po, cl;
                for (int i = 0; i < 2; i++) begin
                    pu[i] = ($urandom_range(0, 99) < pp);
                    po[i] = ($urandom_range(0, 99) < pq);
                    cl[i] = ($urandom_range(0, 99) < 5);
                end
                rstep(pu, po, cl);
            end
        end

        // Mid-stream asynchronous reset at level 3.
        repeat (6) rstep(2'b11, 2'b11, 2'b00);
        repeat (6) rstep(2'b00, 2'b11, 2'b00);
        repeat (3) rstep(2'b01, 2'b00, 2'b00);
        chk("lit_pre_reset_level", 0, 68'(lvl_o[0]), 68'd3);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        chk("lit_async_empty", 0, 68'(empty_o[0]), 68'd1);
        chk("lit_async_level", 0, 68'(lvl_o[0]), 68'd0);
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        step(2'b01, 2'b00, 2'b00, 68'h123, 68'd0);
        chk("lit_post_reset_data", 0, out_o[0][67:0], 68'h123);
        chk("lit_post_reset_valid", 0, 68'(out_o[0][68]), 68'd1);
        rstep(2'b00, 2'b01, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
